imem_load_ctrl: RTL and testbench

//   Sequences a writable instruction memory (64 x 32 async-read RAM) between
//   two users: a program loader (stream of words, valid/ready) and the core's

---
 rtl/imem_load_pkg.sv | 22 ++
 rtl/imem_load_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_load_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_pkg.sv
// Shared definitions for the instruction-memory load controller.
//   state_t    : controller state (HALT, LOAD, FILL, RUN)
//   N_DEF      : default instruction width
//   AW_DEF     : default RAM word-address width
//   DEPTH_DEF  : default RAM depth in words (2**AW_DEF)
//   PAD_INSTR  : fill word, CBZ X31,#0 -- a core fetching it spins in place
package imem_load_pkg;

    localparam int N_DEF     = 32;
    localparam int AW_DEF    = 6;
    localparam int DEPTH_DEF = 64;

    localparam logic [31:0] PAD_INSTR = 32'hb400001f;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller.
// Arbitrates a single-port, async-read instruction RAM between a program
// loader (valid/ready word stream) and the core's fetch port. While a program
// is streamed in, the core is stalled. Unused words are then padded with the
// halt instruction, and the core is released.
//
// Ports
//   clk          : clock, all state on rising edge
//   reset        : asynchronous, active-low reset
//   ld_start     : 1-cycle pulse, begin a new load (any state)
//   ld_valid     : loader word valid
//   ld_data      : loader word
//   ld_last      : final word of the program (qualified by ld_valid)
//   ld_ready     : controller accepts a word this cycle
//   fetch_addr   : core fetch word address
//   fetch_q      : instruction delivered to the core
//   core_stall   : core must hold PC and all state
//   mem_we       : RAM write enable
//   mem_addr     : RAM address (write in LOAD/FILL, fetch in RUN)
//   mem_wdata    : RAM write data
//   mem_rdata    : RAM async read data
//   words_loaded : words accepted by the last/current load (0..DEPTH)
//   load_done    : 1-cycle pulse on the first cycle in RUN
//   err_trunc    : sticky, DEPTH words accepted without ld_last
module imem_load_ctrl #(
    parameter int          N         = imem_load_pkg::N_DEF,
    parameter int          AW        = imem_load_pkg::AW_DEF,
    parameter int          DEPTH     = imem_load_pkg::DEPTH_DEF,
    parameter logic [N-1:0] PAD_INSTR = imem_load_pkg::PAD_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [N-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [AW-1:0] fetch_addr,
    output logic [N-1:0]  fetch_q,
    output logic          core_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata,
    output logic [AW:0]   words_loaded,
    output logic          load_done,
    output logic          err_trunc
);
    import imem_load_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] wptr_reg, wptr_next;
    logic [AW:0]   words_reg, words_next;
    logic          err_reg, err_next;
    logic          done_reg, done_next;
    logic          ready_int;
    logic          accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= HALT;
            wptr_reg  <= '0;
            words_reg <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wptr_reg  <= wptr_next;
            words_reg <= words_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wptr_next  = wptr_reg;
        words_next = words_reg;
        err_next   = err_reg;
        ready_int  = 1'b0;
        accept     = 1'b0;
        core_stall = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fetch_q    = PAD_INSTR;

        case (state_reg)
            HALT: begin
            end
            LOAD: begin
                // A restart takes priority: the word offered alongside it is refused.
                ready_int = !ld_start;
                accept    = ld_valid && ready_int;
                mem_we    = accept;
                mem_addr  = wptr_reg;
                mem_wdata = ld_data;
                if (accept) begin
                    words_next = words_reg + 1'b1;
                    if (wptr_reg == LAST_ADDR) begin
                        // RAM full: nothing left to pad; flag a missing ld_last.
                        state_next = RUN;
                        if (!ld_last) begin
                            err_next = 1'b1;
                        end
                    end else begin
                        wptr_next = wptr_reg + 1'b1;
                        if (ld_last) begin
                            state_next = FILL;
                        end
                    end
                end
            end
            FILL: begin
                mem_we    = 1'b1;
                mem_addr  = wptr_reg;
                mem_wdata = PAD_INSTR;
                // Pointer saturates at the top word rather than wrapping.
                if (wptr_reg == LAST_ADDR) begin
                    state_next = RUN;
                end else begin
                    wptr_next = wptr_reg + 1'b1;
                end
            end
            RUN: begin
                core_stall = 1'b0;
                mem_addr   = fetch_addr;
                fetch_q    = mem_rdata;
            end
            default: begin
                state_next = HALT;
            end
        endcase

        if (ld_start) begin
            state_next = LOAD;
            wptr_next  = '0;
            words_next = '0;
            err_next   = 1'b0;
        end

        // Registered so the pulse coincides with the first cycle in RUN.
        done_next = (state_next == RUN) && (state_reg != RUN);
    end

    assign ld_ready     = ready_int;
    assign words_loaded = words_reg;
    assign err_trunc    = err_reg;
    assign load_done    = done_reg;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed self-checking bench for imem_load_ctrl with a behavioural
// 64 x 32 async-read RAM and a write scoreboard.
module tb_imem_load_ctrl;
    localparam int N     = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam logic [31:0] PAD  = 32'hb400001f;
    localparam logic [31:0] JUNK = 32'hdeadbeef;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_start;
    logic          ld_valid;
    logic [N-1:0]  ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [AW-1:0] fetch_addr;
    logic [N-1:0]  fetch_q;
    logic          core_stall;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;
    logic [AW:0]   words_loaded;
    logic          load_done;
    logic          err_trunc;

    always #5 clk = ~clk;

    logic [N-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    imem_load_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .fetch_addr   (fetch_addr),
        .fetch_q      (fetch_q),
        .core_stall   (core_stall),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .words_loaded (words_loaded),
        .load_done    (load_done),
        .err_trunc    (err_trunc)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } wr_t;

    wr_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    function automatic logic [31:0] mk(int t, int i);
        return {8'(t), 8'ha5, 16'(i * 257)};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int a, logic [31:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        sb.push_back(e);
    endtask

    // Sample at the falling edge; every RAM write must match the scoreboard head.
    task automatic half();
        wr_t e;
        @(negedge clk);
        if (mem_we) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_write observed addr=%0d data=%0h expected=no write", mem_addr, mem_wdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        half();
        finish_cycle();
    endtask

    task automatic send(int a, logic [31:0] d, logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        push(a, d);
        half();
        chk("ld_ready", 64'(ld_ready), 64'(1));
        chk("stall_load", 64'(core_stall), 64'(1));
        finish_cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fill_pads(int from);
        for (int a = from; a < DEPTH; a++) push(a, PAD);
    endtask

    task automatic fetch(int a, logic [31:0] e);
        fetch_addr = AW'(a);
        half();
        chk("fetch_q", 64'(fetch_q), 64'(e));
        finish_cycle();
    endtask

    // Leaves the bench at the falling edge of the first RUN cycle when seen.
    task automatic wait_done(output int fills, output logic seen);
        fills = 0;
        seen  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            half();
            if (load_done) begin
                seen = 1'b1;
                break;
            end
            if (mem_we) fills++;
            finish_cycle();
        end
    endtask

    task automatic pulse_start(logic valid, logic [31:0] d);
        ld_start = 1'b1;
        ld_valid = valid;
        ld_data  = d;
        half();
        chk("we_on_start", 64'(mem_we), 64'(0));
        chk("ready_on_start", 64'(ld_ready), 64'(0));
        finish_cycle();
        ld_start = 1'b0;
        ld_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fills;
        logic seen;

        reset      = 1'b0;
        ld_start   = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        fetch_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        half();
        chk("rst_stall", 64'(core_stall), 64'(1));
        chk("rst_ready", 64'(ld_ready), 64'(0));
        chk("rst_we", 64'(mem_we), 64'(0));
        chk("rst_fetch_q", 64'(fetch_q), 64'(PAD));
        chk("rst_words", 64'(words_loaded), 64'(0));
        chk("rst_err", 64'(err_trunc), 64'(0));
        chk("rst_done", 64'(load_done), 64'(0));
        finish_cycle();
        reset = 1'b1;
        half();
        chk("halt_addr", 64'(mem_addr), 64'(0));
        chk("halt_wdata", 64'(mem_wdata), 64'(0));
        finish_cycle();

        // 7-word program, then 57 pad words
        pulse_start(1'b0, 32'h0);
        for (int i = 0; i < 7; i++) send(i, mk(2, i), (i == 6));
        fill_pads(7);
        wait_done(fills, seen);
        chk("t2_done_seen", 64'(seen), 64'(1));
        chk("t2_fill_cycles", 64'(fills), 64'(57));
        chk("t2_stall", 64'(core_stall), 64'(0));
        chk("t2_we", 64'(mem_we), 64'(0));
        chk("t2_words", 64'(words_loaded), 64'(7));
        chk("t2_err", 64'(err_trunc), 64'(0));
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));
        finish_cycle();
        fetch_addr = AW'(1);
        half();
        chk("t2_done_once", 64'(load_done), 64'(0));
        chk("t2_fetch1", 64'(fetch_q), 64'(mk(2, 1)));
        finish_cycle();
        fetch(6, mk(2, 6));
        fetch(7, PAD);
        fetch(63, PAD);
        $display("load 7 words: fill_cycles=%0d words_loaded=%0d", fills, words_loaded);

        // Gapped valid stream from RUN
        pulse_start(1'b1, JUNK);
        half();
        chk("t3_stall", 64'(core_stall), 64'(1));
        chk("t3_words_clr", 64'(words_loaded), 64'(0));
        finish_cycle();
        for (int i = 0; i < 10; i++) begin
            ld_valid = (i % 2 == 1);
            ld_data  = mk(3, i);
            ld_last  = (i == 9);
            if (ld_valid) push(i / 2, mk(3, i));
            half();
            chk("t3_we", 64'(mem_we), 64'(i % 2 == 1));
            finish_cycle();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        fill_pads(5);
        wait_done(fills, seen);
        chk("t3_done_seen", 64'(seen), 64'(1));
        chk("t3_fill_cycles", 64'(fills), 64'(59));
        chk("t3_words", 64'(words_loaded), 64'(5));
        chk("t3_sb_empty", 64'(sb.size()), 64'(0));
        finish_cycle();
        fetch(0, mk(3, 1));
        fetch(2, mk(3, 5));
        fetch(4, mk(3, 9));
        fetch(5, PAD);
        $display("load 5 gapped words: fill_cycles=%0d words_loaded=%0d", fills, words_loaded);

        // 64 words without ld_last
        pulse_start(1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) send(i, mk(4, i), 1'b0);
        half();
        chk("t4_done", 64'(load_done), 64'(1));
        chk("t4_we", 64'(mem_we), 64'(0));
        chk("t4_stall", 64'(core_stall), 64'(0));
        chk("t4_err", 64'(err_trunc), 64'(1));
        chk("t4_words", 64'(words_loaded), 64'(64));
        chk("t4_sb_empty", 64'(sb.size()), 64'(0));
        finish_cycle();
        fetch(63, mk(4, 63));
        fetch(0, mk(4, 0));
        $display("load 64 words no last: err_trunc=%0d words_loaded=%0d", err_trunc, words_loaded);
        pulse_start(1'b1, JUNK);
        half();
        chk("t4_err_clr", 64'(err_trunc), 64'(0));
        chk("t4_words_clr", 64'(words_loaded), 64'(0));
        chk("t4_stall_reload", 64'(core_stall), 64'(1));
        finish_cycle();

        // Restart in LOAD, during FILL at wptr=20, and during RUN
        pulse_start(1'b1, JUNK);
        for (int i = 0; i < 3; i++) send(i, mk(5, i), (i == 2));
        for (int a = 3; a < 20; a++) begin
            push(a, PAD);
            cyc();
        end
        push(20, PAD);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = JUNK;
        half();
        chk("t5_fill_addr", 64'(mem_addr), 64'(20));
        finish_cycle();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        half();
        chk("t5_stall", 64'(core_stall), 64'(1));
        chk("t5_wptr0", 64'(mem_addr), 64'(0));
        chk("t5_words_clr", 64'(words_loaded), 64'(0));
        finish_cycle();
        send(0, mk(5, 9), 1'b1);
        fill_pads(1);
        wait_done(fills, seen);
        chk("t5_done_seen", 64'(seen), 64'(1));
        chk("t5_fill_cycles", 64'(fills), 64'(63));
        chk("t5_words", 64'(words_loaded), 64'(1));
        chk("t5_sb_empty", 64'(sb.size()), 64'(0));
        finish_cycle();
        fetch(0, mk(5, 9));
        fetch(2, PAD);
        fetch(20, PAD);
        $display("load 1 word after fill restart: fill_cycles=%0d words_loaded=%0d", fills, words_loaded);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = JUNK;
        half();
        chk("t5_run_stall", 64'(core_stall), 64'(0));
        chk("t5_run_we", 64'(mem_we), 64'(0));
        finish_cycle();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        half();
        chk("t5_restart_stall", 64'(core_stall), 64'(1));
        chk("t5_restart_ready", 64'(ld_ready), 64'(1));
        chk("t5_restart_words", 64'(words_loaded), 64'(0));
        chk("t5_restart_fetch", 64'(fetch_q), 64'(PAD));
        finish_cycle();

        // Asynchronous reset mid-LOAD at wptr=3
        for (int i = 0; i < 3; i++) send(i, mk(6, i), 1'b0);
        ld_valid = 1'b1;
        ld_data  = mk(6, 3);
        #2;
        chk("t6_pre_we", 64'(mem_we), 64'(1));
        chk("t6_pre_addr", 64'(mem_addr), 64'(3));
        reset = 1'b0;
        #1;
        chk("t6_we", 64'(mem_we), 64'(0));
        chk("t6_stall", 64'(core_stall), 64'(1));
        chk("t6_ready", 64'(ld_ready), 64'(0));
        chk("t6_words", 64'(words_loaded), 64'(0));
        chk("t6_fetch", 64'(fetch_q), 64'(PAD));
        ld_valid = 1'b0;
        finish_cycle();
        reset = 1'b1;
        half();
        chk("t6_halt_stall", 64'(core_stall), 64'(1));
        chk("t6_halt_ready", 64'(ld_ready), 64'(0));
        chk("t6_sb_empty", 64'(sb.size()), 64'(0));
        finish_cycle();
        $display("reset during load: words_loaded=%0d core_stall=%0d", words_loaded, core_stall);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
